// File: rtl/mda_pkg.sv
// Shared definitions for the MDA raster timing block: default geometry,
// the phase encoding used by both sync counters, and the phase sequencing helper.
package mda_pkg;

  // Default 720x350 MDA geometry
  localparam int unsigned H_TOTAL = 882;
  localparam int unsigned V_TOTAL = 370;
  localparam int unsigned COLS    = 80;
  localparam int unsigned ROWS    = 25;
  localparam int unsigned CHAR_W  = 9;
  localparam int unsigned CHAR_H  = 14;

  // Four phases of a line or a frame: visible, front porch, sync, back porch
  typedef enum logic [1:0] {
    PH_ACT   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYNC  = 2'd2,
    PH_BACK  = 2'd3
  } phase_e;

  // Horizontal and vertical FSMs share the same encoding
  typedef phase_e h_state_e;
  typedef phase_e v_state_e;

  // Next phase with a non-zero length after cur, wrapping BACK -> ACT.
  // Zero-length porches are therefore never entered.
  function automatic phase_e next_live_phase(input phase_e cur,
                                             input int unsigned l0,
                                             input int unsigned l1,
                                             input int unsigned l2,
                                             input int unsigned l3);
    logic [1:0]  idx;
    int unsigned len;
    logic        found;
    phase_e      nxt;
    idx   = cur;
    found = 1'b0;
    nxt   = cur;
    for (int i = 0; i < 4; i++) begin
      idx = idx + 2'd1;
      case (idx)
        2'd0:    len = l0;
        2'd1:    len = l1;
        2'd2:    len = l2;
        default: len = l3;
      endcase
      if (!found && len != 0) begin
        nxt   = phase_e'(idx);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mda_phase_fsm.sv
// Generic four-phase counter/FSM. Counts 0..TOTAL-1 when advance is high and
// walks the phase state across the phase boundaries. The next-cycle count and
// phase are exported so the parent can register decoded outputs in lockstep.
module mda_phase_fsm
  import mda_pkg::*;
#(
  parameter int unsigned L0 = 720,
  parameter int unsigned L1 = 9,
  parameter int unsigned L2 = 135,
  parameter int unsigned L3 = 18,
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [CW-1:0] count,
  output phase_e        phase,
  output logic          wrap,
  output logic [CW-1:0] nxt_count,
  output phase_e        nxt_phase
);

  localparam int unsigned   TOTAL = L0 + L1 + L2 + L3;
  localparam logic [CW-1:0] END0  = CW'(L0 - 1);
  localparam logic [CW-1:0] END1  = CW'(L0 + L1 - 1);
  localparam logic [CW-1:0] END2  = CW'(L0 + L1 + L2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  // Reset sits on the last count, so the phase is the last non-empty one
  localparam phase_e RST_PHASE = (L3 != 0) ? PH_BACK  :
                                 (L2 != 0) ? PH_SYNC  :
                                 (L1 != 0) ? PH_FRONT : PH_ACT;

  logic at_end;

  // Next count/phase: phase moves on when the count leaves the current phase
  always_comb begin
    wrap      = advance && (count == LAST);
    nxt_count = count;
    nxt_phase = phase;
    case (phase)
      PH_ACT:   at_end = (count == END0);
      PH_FRONT: at_end = (count == END1);
      PH_SYNC:  at_end = (count == END2);
      default:  at_end = (count == LAST);
    endcase
    if (advance) begin
      nxt_count = wrap ? '0 : count + CW'(1);
      if (at_end) nxt_phase = next_live_phase(phase, L0, L1, L2, L3);
    end
  end

  // Count and phase state
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
      phase <= RST_PHASE;
    end else begin
      count <= nxt_count;
      phase <= nxt_phase;
    end
  end

endmodule

// File: rtl/mda_timing.sv
// MDA raster sequencer: horizontal/vertical counters, sync generation,
// position counter enable/clear and frame-rate blink clocks. Every output is
// registered from the counters' next state, so outputs describe the
// (h_count, v_count) presented in the same cycle.
module mda_timing
  import mda_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 720,
  parameter int unsigned H_FP       = 9,
  parameter int unsigned H_SYNC     = 135,
  parameter int unsigned H_BP       = 18,
  parameter int unsigned V_ACTIVE   = 350,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 16,
  parameter int unsigned V_BP       = 0,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CURSOR_DIV = 16,
  parameter int unsigned CHAR_DIV   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       video_en,
  output logic [9:0] h_count,
  output logic [8:0] v_count,
  output logic       active,
  output logic       pos_clr,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       cursor_blink,
  output logic       char_blink
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FW = $clog2(2 * CHAR_DIV);

  h_state_e   h_phase, h_nph;
  v_state_e   v_phase, v_nph;
  logic [9:0] h_ncnt;
  logic [8:0] v_ncnt;
  logic       h_wrap, v_wrap;

  logic          en_latched;
  logic          en_n;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] cur_quot;
  logic          char_phase;

  // Current phases are kept as probe points; outputs decode the next phase
  logic unused_phase;
  assign unused_phase = ^{h_phase, v_phase};

  mda_phase_fsm #(
    .L0(H_ACTIVE), .L1(H_FP), .L2(H_SYNC), .L3(H_BP), .CW(10)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .advance   (1'b1),
    .count     (h_count),
    .phase     (h_phase),
    .wrap      (h_wrap),
    .nxt_count (h_ncnt),
    .nxt_phase (h_nph)
  );

  mda_phase_fsm #(
    .L0(V_ACTIVE), .L1(V_FP), .L2(V_SYNC), .L3(V_BP), .CW(9)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .advance   (h_wrap),
    .count     (v_count),
    .phase     (v_phase),
    .wrap      (v_wrap),
    .nxt_count (v_ncnt),
    .nxt_phase (v_nph)
  );

  // Enable seen by the coming cycle: video_en is taken only when a frame
  // starts (v_wrap), so mid-frame changes never cut a frame short.
  // Blink phases are derived from the index of the frame being started.
  always_comb begin
    en_n       = v_wrap ? video_en : en_latched;
    cur_quot   = frame_cnt / FW'(CURSOR_DIV);
    char_phase = (frame_cnt >= FW'(CHAR_DIV));
  end

  // Registered output decode and blink frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      en_latched   <= 1'b0;
      active       <= 1'b0;
      pos_clr      <= 1'b0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
      cursor_blink <= 1'b0;
      char_blink   <= 1'b0;
    end else begin
      en_latched  <= en_n;
      active      <= (h_nph == PH_ACT) && (v_nph == PH_ACT) && en_n;
      pos_clr     <= (h_ncnt == 10'(HT - 1)) && (v_ncnt == 9'(VT - 1));
      hsync       <= (h_nph == PH_SYNC) ? HS_POL : ~HS_POL;
      vsync       <= (v_nph == PH_SYNC) ? VS_POL : ~VS_POL;
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_cnt    <= (frame_cnt == FW'(2 * CHAR_DIV - 1)) ? '0 : frame_cnt + FW'(1);
        cursor_blink <= cur_quot[0];
        char_blink   <= char_phase;
      end
    end
  end

endmodule

// File: tb/tb_mda_timing.sv
// Bench for mda_timing with a shrunken raster (14x8 totals, zero-length
// vertical back porch) so many frames fit in a short run. A reference model
// derives every output from the cycle index since reset release; expected
// vectors are queued at each clock edge and a monitor compares them on the
// falling edge.
module tb_mda_timing;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 1;
  localparam int VA = 5, VF = 1, VSY = 2, VB = 0;
  localparam int CD = 2, CH = 4;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int W  = 26;

  logic       clk = 1'b0;
  logic       rst;
  logic       video_en;
  logic [9:0] h_count;
  logic [8:0] v_count;
  logic       active, pos_clr, hsync, vsync, frame_start;
  logic       cursor_blink, char_blink;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int m_t      = -1;
  bit en_cur   = 1'b0;

  mda_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .CURSOR_DIV(CD), .CHAR_DIV(CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .video_en     (video_en),
    .h_count      (h_count),
    .v_count      (v_count),
    .active       (active),
    .pos_clr      (pos_clr),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start),
    .cursor_blink (cursor_blink),
    .char_blink   (char_blink)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: one expected output vector per clock edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    int h, v, f;
    logic act, pc, hs, vs, fs, cur, chr;
    if (rst) begin
      m_t    = -1;
      en_cur = 1'b0;
      e = {10'(HT - 1), 9'(VT - 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      m_t = m_t + 1;
      if (m_t % FT == 0) en_cur = video_en;
      h   = m_t % HT;
      v   = (m_t / HT) % VT;
      f   = m_t / FT;
      act = (h < HA) && (v < VA) && en_cur;
      pc  = (m_t % FT == FT - 1);
      hs  = (h >= HA + HF) && (h < HA + HF + HSY);
      vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
      fs  = (m_t % FT == 0);
      cur = ((f / CD) % 2) == 1;
      chr = ((f / CH) % 2) == 1;
      e = {10'(h), 9'(v), act, pc, hs, vs, fs, cur, chr};
    end
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation
  always @(negedge clk) begin
    logic [W-1:0] a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {h_count, v_count, active, pos_clr, hsync, vsync, frame_start,
           cursor_blink, char_blink};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0d: actual h=%0d v=%0d flags=%b required h=%0d v=%0d flags=%b",
                 m_t, a[25:16], a[15:7], a[6:0], e[25:16], e[15:7], e[6:0]);
      end
    end
  end

  // Wait (bounded) until the model reaches cycle index target
  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (m_t < target && n < 200 * FT) begin
      @(negedge clk);
      n++;
    end
    if (m_t < target) begin
      checks++;
      failures++;
      $display("FAIL wait_t: actual t=%0d required t=%0d", m_t, target);
    end
  endtask

  // Stimulus
  initial begin
    rst      = 1'b1;
    video_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Frame 0 runs disabled; enable for frame 1
    wait_t(FT / 2);
    video_en = 1'b1;
    // Drop mid-frame 2 at line 3: frame 2 stays visible, frame 3 blank
    wait_t(2 * FT + 3 * HT + 4);
    video_en = 1'b0;
    // Re-enable just before frame 4 starts
    wait_t(4 * FT - 1);
    video_en = 1'b1;
    // Random enable changes, including around frame boundaries
    for (int f = 5; f < 40; f++) begin
      wait_t(f * FT + $urandom_range(0, FT - 1));
      video_en = ($urandom_range(0, 1) == 1);
    end
    // Reset in the middle of a frame, held for a random number of cycles
    wait_t(40 * FT + $urandom_range(HT, FT - 2));
    rst = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    video_en = 1'b1;
    rst      = 1'b0;
    wait_t(3 * FT + 5);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
